// File: rtl/tx_ds_encoder.sv
// Data-strobe character transmitter: picks FCT / NULL / N-char at each character boundary
// and serialises it LSB-first with odd parity, TX_DIV clocks per bit.
module tx_ds_encoder #(
    parameter int unsigned TX_DIV = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable_tx,
    input  logic       send_null,
    input  logic       send_fct,
    input  logic       credit_ok,
    input  logic       ready_tx,
    input  logic [8:0] data_tx_in,
    output logic       fifo_rd_en,
    output logic       dout,
    output logic       sout,
    output logic       fct_sent,
    output logic       busy
);

    localparam logic [7:0] DivLast = 8'(TX_DIV - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e      state_q, state_d;
    logic [7:0]  div_q;
    logic [3:0]  cnt_q;
    logic [9:0]  sh_q;
    logic        hist_q;
    logic        pend_q;
    logic        dout_q;
    logic        sout_q;

    logic        last_clk;
    logic        boundary;
    logic        pick_fct;
    logic        pick_data;
    logic [9:0]  char_bits;
    logic [3:0]  char_len;
    logic        char_hist;

    assign last_clk  = (div_q == DivLast);
    assign boundary  = reset && enable_tx &&
                       ((state_q == StIdle) || ((cnt_q == 4'd1) && last_clk));
    assign pick_fct  = pend_q;
    assign pick_data = !pend_q && !send_null && ready_tx && credit_ok;

    // char_bits[0] is sent first; P is chosen so prev payload + P + flag has odd weight
    always_comb begin
        char_bits = '0;
        char_len  = 4'd0;
        char_hist = 1'b0;
        if (pick_fct) begin
            char_bits = {6'b0, 3'b001, hist_q};
            char_len  = 4'd4;
        end else if (pick_data) begin
            if (!data_tx_in[8]) begin
                char_bits = {data_tx_in[7:0], 1'b0, ~hist_q};
                char_len  = 4'd10;
                char_hist = ^data_tx_in[7:0];
            end else if (!data_tx_in[0]) begin
                char_bits = {6'b0, 3'b101, hist_q};
                char_len  = 4'd4;
                char_hist = 1'b1;
            end else begin
                char_bits = {6'b0, 3'b011, hist_q};
                char_len  = 4'd4;
                char_hist = 1'b1;
            end
        end else begin
            // NULL = ESC then FCT; the inner FCT parity is always 0 after ESC's payload
            char_bits = {2'b00, 7'b0010111, hist_q};
            char_len  = 4'd8;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable_tx) begin
            state_d = StIdle;
        end else if (boundary) begin
            state_d = StShift;
        end
    end

    always_comb begin
        fifo_rd_en = boundary && pick_data;
        fct_sent   = boundary && pick_fct;
        busy       = (state_q == StShift);
        dout       = dout_q;
        sout       = sout_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= (pend_q && !(boundary && pick_fct)) || send_fct;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || !enable_tx) begin
            dout_q <= 1'b0;
            sout_q <= 1'b0;
            sh_q   <= '0;
            cnt_q  <= '0;
            div_q  <= '0;
            hist_q <= 1'b0;
        end else if (boundary) begin
            dout_q <= char_bits[0];
            sout_q <= sout_q ^ (char_bits[0] == dout_q);
            sh_q   <= {1'b0, char_bits[9:1]};
            cnt_q  <= char_len;
            div_q  <= '0;
            hist_q <= char_hist;
        end else if (state_q == StShift) begin
            if (last_clk) begin
                div_q  <= '0;
                dout_q <= sh_q[0];
                sout_q <= sout_q ^ (sh_q[0] == dout_q);
                sh_q   <= {1'b0, sh_q[9:1]};
                cnt_q  <= cnt_q - 4'd1;
            end else begin
                div_q <= div_q + 8'd1;
            end
        end
    end

endmodule
